// File: rtl/m72_pic.sv
// 8-input priority interrupt controller with an ICW/OCW programming model.
// Fixed priority (IR0 highest), edge-triggered requests, optional auto-EOI.
module m72_pic #(
  parameter logic [7:0] RESET_BASE = 8'h20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       a0,
  input  logic       we,
  input  logic       stb,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] irq_in,
  output logic       intr,
  input  logic       inta,
  output logic [7:0] vector
);

  typedef enum logic [1:0] {READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4} state_t;

  state_t      r_state, w_state_n;
  logic [7:0]  r_irr, r_isr, r_imr, r_irq_d, r_dout, r_vector;
  logic [4:0]  r_base;
  logic        r_aeoi, r_rsel, r_sngl, r_ic4, r_intr;

  logic [7:0]  w_irr_n, w_isr_n, w_imr_n, w_dout_n, w_vector_n;
  logic [4:0]  w_base_n;
  logic        w_aeoi_n, w_rsel_n, w_sngl_n, w_ic4_n;
  logic        w_wr, w_rd, w_icw1, w_ready;
  logic [7:0]  w_edge, w_req, w_eoi_ns;
  logic [2:0]  w_win;
  logic        w_win_vld, w_stop, w_eoi_found;

  assign w_wr    = cs & stb & we;
  assign w_rd    = cs & stb & ~we;
  assign w_icw1  = w_wr & ~a0 & din[4];
  assign w_ready = (r_state == READY);
  assign w_edge  = irq_in & ~r_irq_d;
  assign w_req   = r_irr & ~r_imr;

  // Winner: lowest unmasked request below the highest-priority in-service bit.
  always_comb begin
    w_win_vld   = 1'b0;
    w_win       = 3'd7;
    w_stop      = 1'b0;
    w_eoi_ns    = 8'h00;
    w_eoi_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!w_stop) begin
        if (r_isr[i]) begin
          w_stop = 1'b1;
        end else if (w_req[i]) begin
          w_win_vld = 1'b1;
          w_win     = 3'(i);
          w_stop    = 1'b1;
        end
      end
      if (!w_eoi_found && r_isr[i]) begin
        w_eoi_ns[i] = 1'b1;
        w_eoi_found = 1'b1;
      end
    end
  end

  // Next-state and register update logic; ICW1 overrides inta effects.
  always_comb begin
    w_state_n  = r_state;
    w_irr_n    = r_irr;
    w_isr_n    = r_isr;
    w_imr_n    = r_imr;
    w_base_n   = r_base;
    w_aeoi_n   = r_aeoi;
    w_rsel_n   = r_rsel;
    w_sngl_n   = r_sngl;
    w_ic4_n    = r_ic4;
    w_dout_n   = r_dout;
    w_vector_n = r_vector;

    if (inta) begin
      if (w_ready && w_win_vld) begin
        w_vector_n       = {r_base, w_win};
        w_irr_n[w_win]   = 1'b0;
        if (!r_aeoi) w_isr_n[w_win] = 1'b1;
      end else begin
        w_vector_n = {r_base, 3'd7};
      end
    end
    w_irr_n = w_irr_n | w_edge;

    if (w_rd) w_dout_n = a0 ? r_imr : (r_rsel ? r_isr : r_irr);

    if (w_icw1) begin
      w_irr_n   = 8'h00;
      w_isr_n   = 8'h00;
      w_imr_n   = 8'h00;
      w_aeoi_n  = 1'b0;
      w_rsel_n  = 1'b0;
      w_sngl_n  = din[1];
      w_ic4_n   = din[0];
      w_state_n = WAIT_ICW2;
    end else if (w_wr) begin
      case (r_state)
        READY: begin
          if (a0) begin
            w_imr_n = din;
          end else if (din[4:3] == 2'b00) begin
            if (din[7:5] == 3'b001)      w_isr_n = w_isr_n & ~w_eoi_ns;
            else if (din[7:5] == 3'b011) w_isr_n[din[2:0]] = 1'b0;
          end else if (din[4:3] == 2'b01 && din[1]) begin
            w_rsel_n = din[0];
          end
        end
        WAIT_ICW2: if (a0) begin
          w_base_n  = din[7:3];
          w_state_n = !r_sngl ? WAIT_ICW3 : (r_ic4 ? WAIT_ICW4 : READY);
        end
        WAIT_ICW3: if (a0) w_state_n = r_ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: if (a0) begin
          w_aeoi_n  = din[1];
          w_state_n = READY;
        end
        default: w_state_n = READY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= READY;
      r_irr    <= 8'h00;
      r_isr    <= 8'h00;
      r_imr    <= 8'hFF;
      r_base   <= RESET_BASE[7:3];
      r_aeoi   <= 1'b0;
      r_rsel   <= 1'b0;
      r_sngl   <= 1'b0;
      r_ic4    <= 1'b0;
      r_irq_d  <= 8'h00;
      r_intr   <= 1'b0;
      r_dout   <= 8'h00;
      r_vector <= 8'h00;
    end else begin
      r_state  <= w_state_n;
      r_irr    <= w_irr_n;
      r_isr    <= w_isr_n;
      r_imr    <= w_imr_n;
      r_base   <= w_base_n;
      r_aeoi   <= w_aeoi_n;
      r_rsel   <= w_rsel_n;
      r_sngl   <= w_sngl_n;
      r_ic4    <= w_ic4_n;
      r_irq_d  <= irq_in;
      r_intr   <= w_ready & w_win_vld;
      r_dout   <= w_dout_n;
      r_vector <= w_vector_n;
    end
  end

  assign dout   = r_dout;
  assign intr   = r_intr;
  assign vector = r_vector;

endmodule

// File: tb/tb_m72_pic.sv
// Directed bench for m72_pic: programming, priority, nesting, EOI, AEOI, reset.
module tb_m72_pic;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0, a0 = 1'b0, we = 1'b0, stb = 1'b0, inta = 1'b0;
  logic [7:0] din = 8'h00, irq_in = 8'h00;
  logic [7:0] dout, vector;
  logic       intr;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] rd_val;

  m72_pic #(.RESET_BASE(8'h20)) dut (
    .clock(clock), .reset(reset), .cs(cs), .a0(a0), .we(we), .stb(stb),
    .din(din), .dout(dout), .irq_in(irq_in), .intr(intr), .inta(inta),
    .vector(vector)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic ad, input logic [7:0] d);
    cs = 1'b1; stb = 1'b1; we = 1'b1; a0 = ad; din = d;
    cyc();
    cs = 1'b0; stb = 1'b0; we = 1'b0; a0 = 1'b0; din = 8'h00;
  endtask

  task automatic rd(input logic ad, output logic [7:0] v);
    cs = 1'b1; stb = 1'b1; we = 1'b0; a0 = ad;
    cyc();
    cs = 1'b0; stb = 1'b0; a0 = 1'b0;
    v = dout;
  endtask

  task automatic ack();
    inta = 1'b1;
    cyc();
    inta = 1'b0;
  endtask

  task automatic do_reset();
    irq_in = 8'h00;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    cyc(2);
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL reset_intr got %b exp 0", intr); end
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h exp 00", dout); end
    n_vec++; if (vector !== 8'h00) begin n_err++; $display("FAIL reset_vector got %h exp 00", vector); end
    reset = 1'b0;
    cyc();
    rd(1'b1, rd_val);
    n_vec++; if (rd_val !== 8'hFF) begin n_err++; $display("FAIL reset_imr got %h exp ff", rd_val); end
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h00) begin n_err++; $display("FAIL reset_irr got %h exp 00", rd_val); end
  endtask

  task automatic test_basic();
    wr(1'b1, 8'hFC);
    irq_in = 8'h01;
    cyc();
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL basic_latency got %b exp 0", intr); end
    cyc();
    n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL basic_intr got %b exp 1", intr); end
    irq_in = 8'h00;
    ack();
    n_vec++; if (vector !== 8'h20) begin n_err++; $display("FAIL basic_vector got %h exp 20", vector); end
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h00) begin n_err++; $display("FAIL basic_irr got %h exp 00", rd_val); end
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL basic_intr_clr got %b exp 0", intr); end
    wr(1'b0, 8'h0B);
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h01) begin n_err++; $display("FAIL basic_isr got %h exp 01", rd_val); end
  endtask

  task automatic test_priority();
    do_reset();
    wr(1'b1, 8'hFC);
    irq_in = 8'h03;
    cyc(2);
    irq_in = 8'h00;
    n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL prio_intr got %b exp 1", intr); end
    ack();
    n_vec++; if (vector !== 8'h20) begin n_err++; $display("FAIL prio_vec0 got %h exp 20", vector); end
    cyc();
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL prio_blocked got %b exp 0", intr); end
    wr(1'b0, 8'h20);
    cyc();
    n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL prio_after_eoi got %b exp 1", intr); end
    ack();
    n_vec++; if (vector !== 8'h21) begin n_err++; $display("FAIL prio_vec1 got %h exp 21", vector); end
    // ISR=02 now: a higher-priority IR0 edge must nest
    irq_in = 8'h01;
    cyc(2);
    irq_in = 8'h00;
    n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL nest_intr got %b exp 1", intr); end
    ack();
    n_vec++; if (vector !== 8'h20) begin n_err++; $display("FAIL nest_vec got %h exp 20", vector); end
    wr(1'b0, 8'h0B);
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h03) begin n_err++; $display("FAIL nest_isr got %h exp 03", rd_val); end
    wr(1'b0, 8'h20);
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h02) begin n_err++; $display("FAIL nseoi_isr got %h exp 02", rd_val); end
  endtask

  task automatic test_blocked_specific_eoi();
    do_reset();
    wr(1'b1, 8'hFC);
    irq_in = 8'h01;
    cyc(2);
    ack();
    irq_in = 8'h00;
    cyc();
    irq_in = 8'h02;
    cyc(3);
    irq_in = 8'h00;
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL block_intr got %b exp 0", intr); end
    wr(1'b0, 8'h60);
    cyc();
    n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL seoi_intr got %b exp 1", intr); end
    ack();
    n_vec++; if (vector !== 8'h21) begin n_err++; $display("FAIL seoi_vec got %h exp 21", vector); end
  endtask

  task automatic test_aeoi_spurious();
    do_reset();
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h03);
    wr(1'b1, 8'h00);
    irq_in = 8'h04;
    cyc(2);
    irq_in = 8'h00;
    n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL aeoi_intr got %b exp 1", intr); end
    ack();
    n_vec++; if (vector !== 8'h42) begin n_err++; $display("FAIL aeoi_vec got %h exp 42", vector); end
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h00) begin n_err++; $display("FAIL aeoi_irr got %h exp 00", rd_val); end
    wr(1'b0, 8'h0B);
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h00) begin n_err++; $display("FAIL aeoi_isr got %h exp 00", rd_val); end
    ack();
    n_vec++; if (vector !== 8'h47) begin n_err++; $display("FAIL spur_vec got %h exp 47", vector); end
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h00) begin n_err++; $display("FAIL spur_isr got %h exp 00", rd_val); end
    // Not READY: request pending but intr held low and inta spurious
    wr(1'b1, 8'h00);
    irq_in = 8'h01;
    cyc();
    irq_in = 8'h00;
    wr(1'b0, 8'h13);
    irq_in = 8'h01;
    cyc(2);
    irq_in = 8'h00;
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL init_intr got %b exp 0", intr); end
    ack();
    n_vec++; if (vector !== 8'h47) begin n_err++; $display("FAIL init_spur got %h exp 47", vector); end
  endtask

  task automatic test_icw3_path();
    do_reset();
    wr(1'b0, 8'h10);
    wr(1'b1, 8'h80);
    wr(1'b1, 8'h55);
    wr(1'b1, 8'hFE);
    rd(1'b1, rd_val);
    n_vec++; if (rd_val !== 8'hFE) begin n_err++; $display("FAIL icw3_imr got %h exp fe", rd_val); end
    ack();
    n_vec++; if (vector !== 8'h87) begin n_err++; $display("FAIL icw3_base got %h exp 87", vector); end
  endtask

  task automatic test_mask_and_collision();
    do_reset();
    irq_in = 8'h01;
    cyc(2);
    irq_in = 8'h00;
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL mask_intr got %b exp 0", intr); end
    wr(1'b1, 8'hFE);
    cyc();
    n_vec++; if (intr !== 1'b1) begin n_err++; $display("FAIL unmask_intr got %b exp 1", intr); end
    // Edge on IR0 coinciding with the inta that services IR0
    irq_in = 8'h01;
    ack();
    irq_in = 8'h00;
    n_vec++; if (vector !== 8'h20) begin n_err++; $display("FAIL coll_vec got %h exp 20", vector); end
    rd(1'b0, rd_val);
    n_vec++; if (rd_val !== 8'h01) begin n_err++; $display("FAIL coll_irr got %h exp 01", rd_val); end
  endtask

  task automatic test_reset_mid_init();
    do_reset();
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h40);
    ack();
    wr(1'b0, 8'h0B);
    n_vec++; if (vector !== 8'h47) begin n_err++; $display("FAIL mid_pre_vec got %h exp 47", vector); end
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (vector !== 8'h00) begin n_err++; $display("FAIL mid_vec got %h exp 00", vector); end
    n_vec++; if (intr !== 1'b0) begin n_err++; $display("FAIL mid_intr got %b exp 0", intr); end
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL mid_dout got %h exp 00", dout); end
    #2;
    reset = 1'b0;
    cyc();
    wr(1'b1, 8'hFE);
    rd(1'b1, rd_val);
    n_vec++; if (rd_val !== 8'hFE) begin n_err++; $display("FAIL mid_ready got %h exp fe", rd_val); end
    ack();
    n_vec++; if (vector !== 8'h27) begin n_err++; $display("FAIL mid_base got %h exp 27", vector); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_blocked_specific_eoi();
    test_aeoi_spurious();
    test_icw3_path();
    test_mask_and_collision();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
